// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
// Accepts one load/store at a time, holds the pipeline with Stall for a
// fixed number of wait states, then completes the access with a one-cycle
// Ready pulse. Misaligned, out-of-range and read+write requests are
// rejected with Error and never touch the storage array.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Error,
  output logic        Stall
);

  localparam int IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WaitInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT       state;
  logic [3:0]  waitCnt;
  logic [31:0] addrLat;
  logic [31:0] wdataLat;
  logic        rdLat;
  logic        wrLat;

  logic [31:0] memArray [DEPTH_WORDS];

  logic [31:0]     accAddr;
  logic [31:0]     accWdata;
  logic            accRd;
  logic            accWr;
  logic            accBad;
  logic            goResp;
  logic [IdxW-1:0] accIdx;

  // The access being completed: with zero wait states the edge entering
  // RESP is the accept edge itself, so the live inputs are used while IDLE;
  // otherwise the latched copy is used.
  always_comb begin
    accAddr  = addrLat;
    accWdata = wdataLat;
    accRd    = rdLat;
    accWr    = wrLat;
    if (state == IDLE) begin
      accAddr  = Address;
      accWdata = WriteData;
      accRd    = MemRead;
      accWr    = MemWrite;
    end
    accIdx = accAddr[IdxW+1:2];
    accBad = (accAddr[1:0] != 2'b00) ||
             ({2'b00, accAddr[31:2]} >= 32'(DEPTH_WORDS)) ||
             (accRd && accWr);
    goResp = ((state == IDLE) && (MemRead || MemWrite) && (WAIT_CYCLES == 0)) ||
             ((state == WAIT) && (waitCnt == 4'd0));
  end

  // Pipeline hold: asserted from the first cycle a request is seen until RESP.
  assign Stall = ((state == IDLE) && (MemRead || MemWrite)) || (state == WAIT);

  // Control FSM with registered Ready/Error/ReadData; an errored load (any
  // request with MemRead set) returns zero, stores leave ReadData alone.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      waitCnt  <= 4'd0;
      addrLat  <= 32'h0;
      wdataLat <= 32'h0;
      rdLat    <= 1'b0;
      wrLat    <= 1'b0;
      Ready    <= 1'b0;
      Error    <= 1'b0;
      ReadData <= 32'h0;
    end else begin
      Ready <= goResp;
      Error <= goResp && accBad;
      if (goResp && accRd) begin
        ReadData <= accBad ? 32'h0 : memArray[accIdx];
      end
      case (state)
        IDLE: begin
          if (MemRead || MemWrite) begin
            addrLat  <= Address;
            wdataLat <= WriteData;
            rdLat    <= MemRead;
            wrLat    <= MemWrite;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state   <= WAIT;
              waitCnt <= WaitInit;
            end
          end
        end
        WAIT: begin
          if (waitCnt == 4'd0) begin
            state <= RESP;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Storage write on the edge entering RESP; suppressed while reset is held
  // so an abandoned or reset-time request never commits.
  always_ff @(posedge CLK) begin
    if (!RST && goResp && accWr && !accBad) begin
      memArray[accIdx] <= accWdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: two instances (0 and 2 wait states) driven
// with directed and randomized accesses, checked against a word-array model.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        memRead   [2];
  logic        memWrite  [2];
  logic [31:0] address   [2];
  logic [31:0] writeData [2];
  logic [31:0] readData  [2];
  logic        ready     [2];
  logic        error     [2];
  logic        stall     [2];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .CLK(clk), .RST(rst), .MemRead(memRead[0]), .MemWrite(memWrite[0]),
    .Address(address[0]), .WriteData(writeData[0]), .ReadData(readData[0]),
    .Ready(ready[0]), .Error(error[0]), .Stall(stall[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut2 (
    .CLK(clk), .RST(rst), .MemRead(memRead[1]), .MemWrite(memWrite[1]),
    .Address(address[1]), .WriteData(writeData[1]), .ReadData(readData[1]),
    .Ready(ready[1]), .Error(error[1]), .Stall(stall[1])
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: one word array per instance plus the expected ReadData.
  logic [31:0] refMem   [2][DEPTH];
  logic [31:0] refRd    [2];

  // Observations of the most recent access.
  int          obsStall;
  int          obsLat;
  int          obsRespCyc;
  logic        obsErr;
  logic        obsRespStall;
  logic [31:0] obsData;
  bit          obsTimeout;

  function automatic int waitOf(input int s);
    return (s == 0) ? 0 : 2;
  endfunction

  // Model of one access: rules applied directly to a plain word array.
  task automatic model_access(input int s, input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] d,
                              output logic expErr, output logic [31:0] expData);
    logic [31:0] idx;
    idx = a >> 2;
    expErr = (a % 4 != 0) || (idx >= DEPTH) || (r && w);
    if (!expErr && w) refMem[s][idx[7:0]] = d;
    if (r) refRd[s] = expErr ? 32'h0 : refMem[s][idx[7:0]];
    expData = refRd[s];
  endtask

  // Drives one request starting at a falling edge, holds it until Ready,
  // and records stall count, latency, response cycle, Error and ReadData.
  task automatic run_access(input int s, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
    int  firstCyc;
    int  guard;
    bit  seen;
    bit  done;
    memRead[s] = r; memWrite[s] = w; address[s] = a; writeData[s] = d;
    #1;
    obsStall = 0; obsLat = -1; obsTimeout = 0; obsErr = 1'bx; obsData = 32'hx;
    obsRespStall = 1'bx; firstCyc = 0; guard = 0; seen = 0; done = 0;
    while (!done) begin
      if (stall[s]) begin
        if (!seen) begin seen = 1; firstCyc = cyc; end
        obsStall++;
      end
      @(negedge clk);
      guard++;
      if (ready[s]) begin
        done = 1;
        obsErr = error[s]; obsData = readData[s]; obsRespStall = stall[s];
        obsRespCyc = cyc;
        obsLat = seen ? (cyc - firstCyc) : -1;
      end else if (guard > 40) begin
        done = 1; obsTimeout = 1;
      end
    end
    memRead[s] = 1'b0; memWrite[s] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      memRead[s] = 0; memWrite[s] = 0; address[s] = 0; writeData[s] = 0;
      refRd[s] = 32'h0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        total++;
        if ({ready[s], error[s], stall[s], readData[s]} !== 35'h0) begin
          bad++;
          $display("FAIL reset_idle dut%0d cycle%0d: Ready=%b Error=%b Stall=%b ReadData=%h, required all zero",
                   s, c, ready[s], error[s], stall[s], readData[s]);
        end
      end
    end
    $display("test_reset done");
  endtask

  // Preload words 0..63 of both instances so later loads have known data.
  task automatic test_fill();
    logic        e;
    logic [31:0] q;
    logic [31:0] d;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 64; i++) begin
        d = $urandom;
        if (d == 32'h1234_5678) d = d ^ 32'h1;
        model_access(s, 1'b0, 1'b1, 32'(i * 4), d, e, q);
        run_access(s, 1'b0, 1'b1, 32'(i * 4), d);
        total++;
        if (obsTimeout || obsErr !== e || obsStall != waitOf(s) + 1) begin
          bad++;
          $display("FAIL fill dut%0d word%0d: timeout=%0d Error=%b stall=%0d, required Error=%b stall=%0d",
                   s, i, obsTimeout, obsErr, obsStall, e, waitOf(s) + 1);
        end
      end
    end
    $display("test_fill done: 128 stores");
  endtask

  task automatic test_store_load();
    logic        e;
    logic [31:0] q;
    for (int k = 0; k < 2; k++) begin
      logic r;
      r = (k == 1);
      model_access(1, r, !r, 32'h10, 32'hCAFE_0001, e, q);
      run_access(1, r, !r, 32'h10, 32'hCAFE_0001);
      $display("store_load %s 0x10: stall=%0d lat=%0d Error=%b ReadData=%h",
               r ? "load" : "store", obsStall, obsLat, obsErr, obsData);
      total++;
      if (obsTimeout || obsStall != 3 || obsLat != 3 || obsRespStall !== 1'b0) begin
        bad++;
        $display("FAIL store_load_timing %0d: timeout=%0d stall=%0d lat=%0d respStall=%b, required stall=3 lat=3 respStall=0",
                 k, obsTimeout, obsStall, obsLat, obsRespStall);
      end
      total++;
      if (obsErr !== 1'b0 || obsData !== q) begin
        bad++;
        $display("FAIL store_load_data %0d: Error=%b ReadData=%h, required Error=0 ReadData=%h",
                 k, obsErr, obsData, q);
      end
    end
    total++;
    if (q !== 32'hCAFE_0001) begin
      bad++;
      $display("FAIL store_load_model: model word=%h, required cafe0001", q);
    end
  endtask

  task automatic test_errors();
    logic [31:0] aTab [9] = '{32'h12, 32'h400, 32'h10, 32'h10, 32'h10, 32'h11, 32'h10, 32'hFFFF_FFFC, 32'h10};
    logic        rTab [9] = '{1, 1, 1, 1, 1, 0, 1, 0, 1};
    logic        wTab [9] = '{0, 0, 0, 1, 0, 1, 0, 1, 0};
    logic [31:0] dTab [9] = '{0, 0, 0, 32'hFFFF_FFFF, 0, 32'hDEAD_BEEF, 0, 32'h5555_AAAA, 0};
    logic        e;
    logic [31:0] q;
    for (int i = 0; i < 9; i++) begin
      model_access(1, rTab[i], wTab[i], aTab[i], dTab[i], e, q);
      run_access(1, rTab[i], wTab[i], aTab[i], dTab[i]);
      $display("errors #%0d rd=%b wr=%b addr=%h: Error=%b ReadData=%h", i, rTab[i], wTab[i],
               aTab[i], obsErr, obsData);
      total++;
      if (obsTimeout || obsErr !== e || obsData !== q || obsStall != 3 || obsLat != 3) begin
        bad++;
        $display("FAIL errors #%0d: timeout=%0d Error=%b ReadData=%h stall=%0d lat=%0d, required Error=%b ReadData=%h stall=3 lat=3",
                 i, obsTimeout, obsErr, obsData, obsStall, obsLat, e, q);
      end
    end
  endtask

  task automatic test_random();
    logic        e;
    logic [31:0] q;
    logic [31:0] a;
    logic [31:0] d;
    logic        r;
    logic        w;
    int          s;
    int          fails;
    fails = 0;
    for (int i = 0; i < 80; i++) begin
      s = int'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: begin r = 1; w = 1; end
        1, 2, 3: begin r = 0; w = 1; end
        default: begin r = 1; w = 0; end
      endcase
      if ($urandom_range(0, 4) == 0) begin
        a = $urandom;
        if (a < 32'h400 && a[1:0] == 2'b00) a = a | 32'h1;
      end else begin
        a = 32'($urandom_range(0, 63)) * 4;
      end
      d = $urandom;
      model_access(s, r, w, a, d, e, q);
      run_access(s, r, w, a, d);
      total++;
      if (obsTimeout || obsErr !== e || obsData !== q || obsStall != waitOf(s) + 1 ||
          obsLat != waitOf(s) + 1) begin
        bad++; fails++;
        $display("FAIL random #%0d dut%0d rd=%b wr=%b addr=%h: timeout=%0d Error=%b ReadData=%h stall=%0d lat=%0d, required Error=%b ReadData=%h stall=lat=%0d",
                 i, s, r, w, a, obsTimeout, obsErr, obsData, obsStall, obsLat, e, q, waitOf(s) + 1);
      end
    end
    $display("test_random done: 80 accesses, %0d mismatching", fails);
  endtask

  // Zero-wait instance: alternating store/load in every available slot.
  task automatic test_back_to_back();
    logic        e;
    logic [31:0] q;
    logic [31:0] a;
    logic [31:0] d;
    int          prevResp;
    prevResp = 0;
    for (int i = 0; i < 16; i++) begin
      logic r;
      r = i[0];
      a = 32'((i / 2) * 4 + 128);
      d = $urandom;
      model_access(0, r, !r, a, d, e, q);
      run_access(0, r, !r, a, d);
      $display("b2b #%0d %s addr=%h: respCycle=%0d ReadData=%h", i, r ? "load" : "store", a,
               obsRespCyc, obsData);
      total++;
      if (obsTimeout || obsStall != 1 || obsLat != 1 || obsErr !== 1'b0 || obsData !== q) begin
        bad++;
        $display("FAIL b2b #%0d: timeout=%0d stall=%0d lat=%0d Error=%b ReadData=%h, required stall=1 lat=1 Error=0 ReadData=%h",
                 i, obsTimeout, obsStall, obsLat, obsErr, obsData, q);
      end
      if (i > 0) begin
        total++;
        if (obsRespCyc - prevResp != 2) begin
          bad++;
          $display("FAIL b2b_spacing #%0d: gap=%0d, required 2", i, obsRespCyc - prevResp);
        end
      end
      prevResp = obsRespCyc;
    end
  endtask

  task automatic test_reset_mid_wait();
    logic        e;
    logic [31:0] q;
    logic [31:0] oldWord;
    oldWord = refMem[1][8];
    // Abandoned store: reset in WAIT, request dropped before release.
    memWrite[1] = 1; address[1] = 32'h20; writeData[1] = 32'h1234_5678;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    memWrite[1] = 0;
    rst = 1'b0;
    refRd[0] = 32'h0; refRd[1] = 32'h0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (ready[1] !== 1'b0 || readData[1] !== 32'h0) begin
        bad++;
        $display("FAIL rst_wait_noready c%0d: Ready=%b ReadData=%h, required 0/0", c, ready[1], readData[1]);
      end
      @(negedge clk);
    end
    model_access(1, 1'b1, 1'b0, 32'h20, 32'h0, e, q);
    run_access(1, 1'b1, 1'b0, 32'h20, 32'h0);
    $display("rst_wait abandoned store, load 0x20: ReadData=%h", obsData);
    total++;
    if (obsTimeout || obsErr !== 1'b0 || obsData !== oldWord || obsData === 32'h1234_5678) begin
      bad++;
      $display("FAIL rst_wait_abandon: ReadData=%h Error=%b, required ReadData=%h Error=0", obsData, obsErr, oldWord);
    end
    // Held store: reset in WAIT with the request still held is re-accepted.
    memWrite[1] = 1; address[1] = 32'h20; writeData[1] = 32'h1234_5678;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    refRd[0] = 32'h0; refRd[1] = 32'h0;
    model_access(1, 1'b0, 1'b1, 32'h20, 32'h1234_5678, e, q);
    run_access(1, 1'b0, 1'b1, 32'h20, 32'h1234_5678);
    total++;
    if (obsTimeout || obsErr !== 1'b0 || obsStall != 3 || obsLat != 3) begin
      bad++;
      $display("FAIL rst_wait_reaccept: timeout=%0d Error=%b stall=%0d lat=%0d, required Error=0 stall=3 lat=3",
               obsTimeout, obsErr, obsStall, obsLat);
    end
    model_access(1, 1'b1, 1'b0, 32'h20, 32'h0, e, q);
    run_access(1, 1'b1, 1'b0, 32'h20, 32'h0);
    $display("rst_wait reissued store, load 0x20: ReadData=%h", obsData);
    total++;
    if (obsData !== q || q !== 32'h1234_5678) begin
      bad++;
      $display("FAIL rst_wait_reissue: ReadData=%h, required 12345678", obsData);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_store_load();
    test_errors();
    test_random();
    test_back_to_back();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
